i2c_accel_poller: RTL and testbench

//  Upstream sequencer for the I2C master: drives its start/rw/addr/data/len command port.

---
 rtl/i2c_accel_poller_pkg.sv | 35 +++
 rtl/i2c_accel_poller_if.sv | 26 ++
 rtl/i2c_accel_poller_txn_issuer.sv | 112 +++++++++++
 rtl/i2c_accel_poller.sv | 156 +++++++++++++++
 tb/tb_i2c_accel_poller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_accel_poller_pkg.sv
// Shared types and helpers for the accelerometer poller and its transaction issuer.
// Holds FSM encodings, transaction lengths, axis register addressing and a saturating counter.
package i2c_accel_poller_pkg;

   typedef enum logic [2:0] {
      S_INIT,
      S_INIT_WAIT,
      S_WAIT,
      S_PTR,
      S_RD,
      S_OUT,
      S_ABORT
   } state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_REQ,
      T_RUN,
      T_DONE
   } txn_state_t;

   localparam logic [1:0] LEN_1     = 2'd1;
   localparam logic [1:0] LEN_2     = 2'd2;
   localparam logic [1:0] LAST_AXIS = 2'd2;

   // Axis registers are two bytes apart: X at base, Y at base+2, Z at base+4.
   function automatic logic [7:0] axis_reg(input logic [7:0] base, input logic [1:0] axis);
      return base + {5'd0, axis, 1'b0};
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_accel_poller_if.sv
// Command port toward the I2C master plus the 48-bit sample stream toward the consumer.
// The poller uses the master modport; the master/consumer side uses the slave modport.
interface i2c_accel_poller_if;
   logic        m_start;
   logic        m_rw;
   logic [6:0]  m_slave_addr;
   logic [15:0] m_w_data;
   logic [1:0]  m_data_len;
   logic [15:0] m_r_data;
   logic        m_busy;
   logic        m_ack_error;
   logic        m_done;
   logic [47:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;

   modport master (
      output m_start, m_rw, m_slave_addr, m_w_data, m_data_len, sample_data, sample_valid,
      input  m_r_data, m_busy, m_ack_error, m_done, sample_ready
   );

   modport slave (
      input  m_start, m_rw, m_slave_addr, m_w_data, m_data_len, sample_data, sample_valid,
      output m_r_data, m_busy, m_ack_error, m_done, sample_ready
   );
endinterface

// File: rtl/i2c_accel_poller_txn_issuer.sv
// Runs one master transaction per request: start/busy handshake, done-edge detect, timeout.
// Result pulses appear 2 cycles after the done edge; a new request is not taken until busy is low.
module i2c_accel_poller_txn_issuer
   import i2c_accel_poller_pkg::*;
#(
   parameter int TIMEOUT = 100_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic        i_rw,
   input  logic [15:0] i_w_data,
   input  logic [1:0]  i_len,
   input  logic        i_busy,
   input  logic        i_done,
   input  logic        i_ack_error,
   input  logic [15:0] i_r_data,
   output logic        o_start,
   output logic        o_rw,
   output logic [15:0] o_w_data,
   output logic [1:0]  o_len,
   output logic        o_ok,
   output logic        o_nack,
   output logic        o_timeout,
   output logic [15:0] o_r_data
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   txn_state_t  r_st, w_nxt;
   logic          r_done_q, r_done_qq;
   logic [TW-1:0] r_tcnt;
   logic          r_start, r_rw, r_ok, r_nack, r_tmo;
   logic [15:0]   r_w_data, r_r_data;
   logic [1:0]    r_len;
   logic          w_done_edge, w_expired, w_ok, w_nack, w_tmo;

   assign w_done_edge = r_done_q & ~r_done_qq;
   assign w_expired   = (r_tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      w_nxt  = r_st;
      w_ok   = 1'b0;
      w_nack = 1'b0;
      w_tmo  = 1'b0;
      case (r_st)
         T_IDLE: if (i_req && !i_busy) w_nxt = T_REQ;
         T_REQ, T_RUN: begin
            if (w_done_edge) begin
               w_nxt  = T_DONE;
               w_ok   = !i_ack_error;
               w_nack = i_ack_error;
            end else if (w_expired) begin
               w_nxt = T_DONE;
               w_tmo = 1'b1;
            end else if (r_st == T_REQ && i_busy) begin
               w_nxt = T_RUN;
            end
         end
         T_DONE:  w_nxt = T_IDLE;
         default: w_nxt = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_st <= T_IDLE;
      else          r_st <= w_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done_q  <= 1'b0;
         r_done_qq <= 1'b0;
         r_tcnt    <= '0;
         r_start   <= 1'b0;
         r_rw      <= 1'b0;
         r_w_data  <= '0;
         r_len     <= '0;
         r_ok      <= 1'b0;
         r_nack    <= 1'b0;
         r_tmo     <= 1'b0;
         r_r_data  <= '0;
      end else begin
         r_done_q  <= i_done;
         r_done_qq <= r_done_q;
         r_start   <= (w_nxt == T_REQ);
         r_ok      <= w_ok;
         r_nack    <= w_nack;
         r_tmo     <= w_tmo;
         // Command fields are latched at start rise and held until the next request.
         if (r_st == T_IDLE && w_nxt == T_REQ) begin
            r_rw     <= i_rw;
            r_w_data <= i_w_data;
            r_len    <= i_len;
            r_tcnt   <= '0;
         end else if (r_st == T_REQ || r_st == T_RUN) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         if (w_ok || w_nack) r_r_data <= i_r_data;
      end
   end

   assign o_start   = r_start;
   assign o_rw      = r_rw;
   assign o_w_data  = r_w_data;
   assign o_len     = r_len;
   assign o_ok      = r_ok;
   assign o_nack    = r_nack;
   assign o_timeout = r_tmo;
   assign o_r_data  = r_r_data;

endmodule

// File: rtl/i2c_accel_poller.sv
// Sequences the I2C master: one config write after reset, then an X/Y/Z burst every SAMPLE_PERIOD.
// One 48-bit sample per period on valid/ready; an unconsumed sample blocks the new one and pulses overrun.
module i2c_accel_poller
   import i2c_accel_poller_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR    = 7'h53,
   parameter logic [7:0] INIT_REG      = 8'h2D,
   parameter logic [7:0] INIT_VAL      = 8'h08,
   parameter logic [7:0] DATA_REG      = 8'h32,
   parameter int         SAMPLE_PERIOD = 1_000_000,
   parameter int         TIMEOUT       = 100_000,
   parameter bit         BYTE_SWAP     = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   i2c_accel_poller_if.master bus,
   output logic               init_done,
   output logic               overrun,
   output logic [7:0]         err_cnt
);

   localparam int PW = $clog2(SAMPLE_PERIOD);

   state_t        r_state, w_next;
   logic [PW-1:0] r_period;
   logic          r_tick, r_init_done, r_overrun, r_valid;
   logic [1:0]    r_axis;
   logic [47:0]   r_acc, r_sample;
   logic [7:0]    r_err;

   logic        w_req, w_rw, w_take;
   logic [15:0] w_wdata, w_rdata, w_word;
   logic [1:0]  w_len;
   logic        w_ok, w_nack, w_tmo;
   logic        w_start, w_cmd_rw;
   logic [15:0] w_cmd_wdata;
   logic [1:0]  w_cmd_len;

   i2c_accel_poller_txn_issuer #(.TIMEOUT(TIMEOUT)) u_issuer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_req      (w_req),
      .i_rw       (w_rw),
      .i_w_data   (w_wdata),
      .i_len      (w_len),
      .i_busy     (bus.m_busy),
      .i_done     (bus.m_done),
      .i_ack_error(bus.m_ack_error),
      .i_r_data   (bus.m_r_data),
      .o_start    (w_start),
      .o_rw       (w_cmd_rw),
      .o_w_data   (w_cmd_wdata),
      .o_len      (w_cmd_len),
      .o_ok       (w_ok),
      .o_nack     (w_nack),
      .o_timeout  (w_tmo),
      .o_r_data   (w_rdata)
   );

   always_comb begin
      w_next  = r_state;
      w_req   = 1'b0;
      w_rw    = 1'b0;
      w_wdata = '0;
      w_len   = LEN_1;
      case (r_state)
         S_INIT: begin
            w_req   = 1'b1;
            w_len   = LEN_2;
            w_wdata = {INIT_REG, INIT_VAL};
            if (w_ok)                w_next = S_WAIT;
            else if (w_nack || w_tmo) w_next = S_INIT_WAIT;
         end
         S_INIT_WAIT: if (r_tick) w_next = S_INIT;
         S_WAIT:      if (r_tick && enable && r_init_done) w_next = S_PTR;
         S_PTR: begin
            w_req   = 1'b1;
            w_wdata = {8'h00, axis_reg(DATA_REG, r_axis)};
            if (w_ok)                w_next = S_RD;
            else if (w_nack || w_tmo) w_next = S_ABORT;
         end
         S_RD: begin
            // The master NACKs the final read byte itself, so a read NACK still carries data.
            w_req = 1'b1;
            w_rw  = 1'b1;
            w_len = LEN_2;
            if (w_ok || w_nack) w_next = (r_axis == LAST_AXIS) ? S_OUT : S_PTR;
            else if (w_tmo)     w_next = S_ABORT;
         end
         S_OUT:   w_next = S_WAIT;
         S_ABORT: w_next = S_WAIT;
         default: w_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_INIT;
      else          r_state <= w_next;
   end

   assign w_take = (r_state == S_WAIT && w_next == S_PTR) ||
                   (r_state == S_INIT_WAIT && w_next == S_INIT);
   assign w_word = BYTE_SWAP ? {w_rdata[7:0], w_rdata[15:8]} : w_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_period    <= PW'(SAMPLE_PERIOD - 1);
         r_tick      <= 1'b0;
         r_init_done <= 1'b0;
         r_overrun   <= 1'b0;
         r_valid     <= 1'b0;
         r_axis      <= '0;
         r_acc       <= '0;
         r_sample    <= '0;
         r_err       <= '0;
      end else begin
         r_overrun <= 1'b0;
         r_period  <= (r_period == '0) ? PW'(SAMPLE_PERIOD - 1) : r_period - 1'b1;
         // Only one tick is remembered; a wrap while one is pending is lost.
         if (r_period == '0) r_tick <= 1'b1;
         else if (w_take)    r_tick <= 1'b0;
         if (r_state == S_INIT && w_ok) r_init_done <= 1'b1;
         if ((r_state == S_INIT && (w_nack || w_tmo)) || r_state == S_ABORT)
            r_err <= sat_inc8(r_err);
         if (r_state == S_WAIT && w_next == S_PTR) r_axis <= '0;
         if (r_state == S_RD && (w_ok || w_nack)) begin
            r_axis <= r_axis + 2'd1;
            case (r_axis)
               2'd0:    r_acc[15:0]  <= w_word;
               2'd1:    r_acc[31:16] <= w_word;
               default: r_acc[47:32] <= w_word;
            endcase
         end
         if (r_state == S_OUT && !(r_valid && !bus.sample_ready)) begin
            r_sample <= r_acc;
            r_valid  <= 1'b1;
         end else begin
            if (r_state == S_OUT)              r_overrun <= 1'b1;
            if (r_valid && bus.sample_ready)   r_valid   <= 1'b0;
         end
      end
   end

   assign bus.m_start      = w_start;
   assign bus.m_rw         = w_cmd_rw;
   assign bus.m_slave_addr = SLAVE_ADDR;
   assign bus.m_w_data     = w_cmd_wdata;
   assign bus.m_data_len   = w_cmd_len;
   assign bus.sample_data  = r_sample;
   assign bus.sample_valid = r_valid;
   assign init_done        = r_init_done;
   assign overrun          = r_overrun;
   assign err_cnt          = r_err;

endmodule

// File: tb/tb_i2c_accel_poller.sv
// Directed bench: fixed-latency master model with NACK/hang injection around the poller.
// Checks init write, sample assembly, overrun, NACK abort, timeout, reset and enable handling.
`timescale 1ns/1ps
module tb_i2c_accel_poller;
   localparam int SP  = 300;
   localparam int TMO = 60;
   localparam int LAT = 5;

   localparam int W_VALID = 0;
   localparam int W_INIT  = 1;
   localparam int W_ERR   = 2;
   localparam int W_NTX   = 3;
   localparam int W_OV    = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       init_done, overrun;
   logic [7:0] err_cnt;

   i2c_accel_poller_if bus();

   i2c_accel_poller #(.SAMPLE_PERIOD(SP), .TIMEOUT(TMO)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .bus      (bus),
      .init_done(init_done),
      .overrun  (overrun),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ntx = 0;
   int          ov_cnt = 0;
   int          hold_err = 0;
   int          rst_cnt = 0;
   int          start_cyc = 0;
   logic        hang = 1'b0;
   logic        nack_y = 1'b0;
   logic [15:0] dx, dy, dz;
   logic        log_rw  [0:63];
   logic [15:0] log_wd  [0:63];
   logic [1:0]  log_len [0:63];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (overrun === 1'b1) ov_cnt = ov_cnt + 1;

   // Master model: busy one half-cycle after start, done held 3 cycles after LAT cycles.
   initial begin
      logic        rw;
      logic [15:0] wd, word, rdata;
      logic [1:0]  len;
      logic [7:0]  ptr;
      logic        ack;
      int          rc;
      ptr = 8'h00;
      bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack_error = 1'b0; bus.m_r_data = '0;
      forever begin
         @(negedge clk);
         if (reset_n && bus.m_start === 1'b1 && !bus.m_busy) begin
            rw = bus.m_rw; wd = bus.m_w_data; len = bus.m_data_len; rc = rst_cnt;
            if (ntx < 64) begin
               log_rw[ntx] = rw; log_wd[ntx] = wd; log_len[ntx] = len;
            end
            ntx = ntx + 1;
            start_cyc = cyc;
            bus.m_busy = 1'b1;
            if (hang) begin
               hang = 1'b0;
               repeat (TMO + 40) @(negedge clk);
               bus.m_busy = 1'b0;
            end else begin
               ack = 1'b0; rdata = '0; word = '0;
               if (!rw) begin
                  if (len == 2'd1) ptr = wd[7:0];
                  if (nack_y && wd == 16'h0034) begin ack = 1'b1; nack_y = 1'b0; end
               end else begin
                  case (ptr)
                     8'h32:   word = dx;
                     8'h34:   word = dy;
                     8'h36:   word = dz;
                     default: word = 16'hDEAD;
                  endcase
                  rdata = {word[7:0], word[15:8]};
               end
               repeat (LAT) @(negedge clk);
               if (rc == rst_cnt && (bus.m_rw !== rw || bus.m_w_data !== wd || bus.m_data_len !== len))
                  hold_err = hold_err + 1;
               bus.m_r_data = rdata; bus.m_ack_error = ack; bus.m_done = 1'b1;
               repeat (3) @(negedge clk);
               bus.m_done = 1'b0; bus.m_busy = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cond(input int what, input int target);
      case (what)
         W_VALID: return bus.sample_valid === 1'b1;
         W_INIT:  return init_done === 1'b1;
         W_ERR:   return err_cnt === 8'(target);
         W_NTX:   return ntx >= target;
         default: return ov_cnt >= target;
      endcase
   endfunction

   task automatic wait_for(input int what, input int target, input int budget, input string tag);
      int n = 0;
      while (!cond(what, target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, " reached"}, 64'(cond(what, target)), 64'd1);
   endtask

   task automatic consume();
      bus.sample_ready = 1'b1;
      @(negedge clk);
      bus.sample_ready = 1'b0;
      check("consume clears valid", 64'(bus.sample_valid), 64'd0);
   endtask

   initial begin
      int base;
      int elapsed;
      bus.sample_ready = 1'b0;
      dx = 16'h0102; dy = 16'h0304; dz = 16'h0506;
      reset_n = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst m_start", 64'(bus.m_start), 64'd0);
      check("rst m_slave_addr", 64'(bus.m_slave_addr), 64'h53);
      check("rst m_w_data", 64'(bus.m_w_data), 64'd0);
      check("rst m_data_len", 64'(bus.m_data_len), 64'd0);
      check("rst sample_valid", 64'(bus.sample_valid), 64'd0);
      check("rst sample_data", 64'(bus.sample_data), 64'd0);
      check("rst init_done", 64'(init_done), 64'd0);
      check("rst err_cnt", 64'(err_cnt), 64'd0);
      reset_n = 1'b1;

      // Config write right after reset
      wait_for(W_INIT, 0, 200, "init_done");
      check("init txn count", 64'(ntx), 64'd1);
      check("init rw", 64'(log_rw[0]), 64'd0);
      check("init w_data", 64'(log_wd[0]), 64'h2D08);
      check("init len", 64'(log_len[0]), 64'd2);

      // First sample: six transactions, low byte first from the device
      wait_for(W_VALID, 0, 2 * SP, "sample1");
      check("sample1 txn count", 64'(ntx), 64'd7);
      check("sample1 data", 64'(bus.sample_data), 64'h0506_0304_0102);
      check("ptr X w_data", 64'(log_wd[1]), 64'h0032);
      check("ptr X len", 64'(log_len[1]), 64'd1);
      check("rd X rw", 64'(log_rw[2]), 64'd1);
      check("rd X len", 64'(log_len[2]), 64'd2);
      check("ptr Y w_data", 64'(log_wd[3]), 64'h0034);
      check("ptr Z w_data", 64'(log_wd[5]), 64'h0036);
      check("sample1 err_cnt", 64'(err_cnt), 64'd0);

      // Unconsumed sample across the next period
      dx = 16'h1112; dy = 16'h1314; dz = 16'h1516;
      wait_for(W_OV, 1, SP + 150, "overrun");
      repeat (5) @(negedge clk);
      check("overrun count", 64'(ov_cnt), 64'd1);
      check("overrun keeps old", 64'(bus.sample_data), 64'h0506_0304_0102);
      check("overrun valid held", 64'(bus.sample_valid), 64'd1);
      check("overrun err_cnt", 64'(err_cnt), 64'd0);
      consume();

      // Pointer write for Y is NACKed
      dx = 16'h2122; dy = 16'h2324; dz = 16'h2526; nack_y = 1'b1;
      wait_for(W_ERR, 1, SP + 150, "nack err_cnt");
      check("nack no sample", 64'(bus.sample_valid), 64'd0);
      wait_for(W_VALID, 0, SP + 150, "sample after nack");
      check("sample after nack", 64'(bus.sample_data), 64'h2526_2324_2122);
      check("err_cnt after nack", 64'(err_cnt), 64'd1);
      check("no extra overrun", 64'(ov_cnt), 64'd1);
      consume();

      // Master never signals done
      dx = 16'h3132; dy = 16'h3334; dz = 16'h3536; hang = 1'b1;
      wait_for(W_ERR, 2, SP + TMO + 150, "timeout err_cnt");
      elapsed = cyc - start_cyc;
      check("timeout latency", 64'(elapsed >= TMO && elapsed <= TMO + 4), 64'd1);
      check("timeout m_start low", 64'(bus.m_start), 64'd0);
      wait_for(W_VALID, 0, SP + 200, "sample after timeout");
      check("sample after timeout", 64'(bus.sample_data), 64'h3536_3334_3132);
      check("err_cnt after timeout", 64'(err_cnt), 64'd2);
      consume();

      // Reset pulse while a read is in flight
      base = ntx;
      wait_for(W_NTX, base + 2, SP + 150, "reach read");
      repeat (2) @(negedge clk);
      check("in read txn", 64'(log_rw[ntx - 1]), 64'd1);
      reset_n = 1'b0; rst_cnt++;
      #1;
      check("mid-rd rst m_start", 64'(bus.m_start), 64'd0);
      check("mid-rd rst init_done", 64'(init_done), 64'd0);
      check("mid-rd rst err_cnt", 64'(err_cnt), 64'd0);
      check("mid-rd rst m_data_len", 64'(bus.m_data_len), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      base = ntx;
      wait_for(W_INIT, 0, 200, "re-init");
      check("re-init w_data", 64'(log_wd[base]), 64'h2D08);
      check("re-init txn count", 64'(ntx), 64'(base + 1));

      // enable drops mid-sample: sample completes, then the poller idles
      dx = 16'h4142; dy = 16'h4344; dz = 16'h4546;
      base = ntx;
      wait_for(W_NTX, base + 1, 2 * SP, "sample start");
      enable = 1'b0;
      wait_for(W_VALID, 0, 200, "sample with enable low");
      check("enable-low sample", 64'(bus.sample_data), 64'h4546_4344_4142);
      base = ntx;
      repeat (2 * SP + 20) @(negedge clk);
      check("idle while disabled", 64'(ntx), 64'(base));
      check("valid held while disabled", 64'(bus.sample_valid), 64'd1);
      consume();
      dx = 16'h5152; dy = 16'h5354; dz = 16'h5556;
      enable = 1'b1;
      wait_for(W_VALID, 0, 120, "pending tick resumes");
      check("resume txn count", 64'(ntx), 64'(base + 6));
      check("resume sample", 64'(bus.sample_data), 64'h5556_5354_5152);
      check("command hold", 64'(hold_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
